// File: rtl/led_stream_pkg.sv
// led_stream_pkg: field layout and shared types for the LED stream capture.
// Optional macro used by this slice: LED_CAPTURE_DIFF_EN.
package led_stream_pkg;

  localparam int R_BIT = 9;
  localparam int G_BIT = 8;
  localparam int Y_MSB = 6;
  localparam int Y_LSB = 3;
  localparam int X_MSB = 2;
  localparam int X_LSB = 0;

  localparam int ROWS = 16;
  localparam int COLS = 8;

  typedef logic [COLS-1:0] row_t;

  typedef struct packed {
    logic       r;
    logic       g;
    logic       rsvd;
    logic [3:0] y;
    logic [2:0] x;
  } word_t;

  // Bit 7 is reserved and never takes part in run matching.
  localparam logic [9:0] WORD_MASK = 10'h37F;

  function automatic logic is_blank(word_t w);
    return !(w.r || w.g);
  endfunction

endpackage

// File: rtl/led_stream_capture_if.sv
// led_stream_capture_if: stream input, frame sync and row readback bundle.
// With LED_CAPTURE_DIFF_EN the frame-diff outputs are carried as well.
interface led_stream_capture_if;
  import led_stream_pkg::*;

  logic [9:0] LEDIN;
  logic       FRAME_SYNC;
  logic [3:0] RD_Y;
  row_t       RD_R;
  row_t       RD_G;
  logic       FRAME_DONE;
  logic [7:0] CNT_R;
  logic [7:0] CNT_G;
`ifdef LED_CAPTURE_DIFF_EN
  logic        CHANGED;
  logic [15:0] ROW_DIFF;

  modport master (
    output LEDIN, FRAME_SYNC, RD_Y,
    input  RD_R, RD_G, FRAME_DONE,
    input  CNT_R, CNT_G,
    input  CHANGED, ROW_DIFF
  );

  modport slave (
    input  LEDIN, FRAME_SYNC, RD_Y,
    output RD_R, RD_G, FRAME_DONE,
    output CNT_R, CNT_G,
    output CHANGED, ROW_DIFF
  );
`else
  modport master (
    output LEDIN, FRAME_SYNC, RD_Y,
    input  RD_R, RD_G, FRAME_DONE,
    input  CNT_R, CNT_G
  );

  modport slave (
    input  LEDIN, FRAME_SYNC, RD_Y,
    output RD_R, RD_G, FRAME_DONE,
    output CNT_R, CNT_G
  );
`endif

endinterface

// File: rtl/led_dwell_filter.sv
// led_dwell_filter: decodes stream words and accepts a pixel once per
// run of MIN_DWELL identical non-blank cycles (glitch rejection).
module led_dwell_filter
  import led_stream_pkg::*;
#(
  parameter int MIN_DWELL = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] ledin,
  output logic       accept,
  output logic       r,
  output logic       g,
  output logic [3:0] y,
  output logic [2:0] x
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  typedef logic [DW-1:0] dw_t;
  localparam dw_t DMAX = dw_t'(MIN_DWELL);

  word_t cur;
  word_t prev;
  dw_t   dwell;
  dw_t   dwell_next;
  logic  blank;
  logic  cont;

  // Run tracking: saturate at MIN_DWELL so accept can only fire once.
  always_comb begin
    cur   = word_t'(ledin & WORD_MASK);
    blank = is_blank(cur);
    cont  = !blank && (cur == prev);
    dwell_next = '0;
    if (cont) begin
      dwell_next = (dwell == DMAX) ? dwell : dwell + dw_t'(1);
    end else if (!blank) begin
      dwell_next = dw_t'(1);
    end
    accept = (dwell_next == DMAX) && !(cont && dwell == DMAX);
  end

  assign r = cur.r;
  assign g = cur.g;
  assign y = cur.y;
  assign x = cur.x;

  // Previous masked word and run length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= '0;
      dwell <= '0;
    end else begin
      prev  <= cur;
      dwell <= dwell_next;
    end
  end

endmodule

// File: rtl/led_stream_capture.sv
// led_stream_capture: captures the LED pixel stream into a 16x8 two-colour
// frame buffer and swaps it out each frame. Optional: LED_CAPTURE_DIFF_EN.
module led_stream_capture
  import led_stream_pkg::*;
#(
  parameter int FRAME_CYCLES = 256128,
  parameter int MIN_DWELL    = 16,
  parameter int TIMER_W      = 18
) (
  input logic CLK,
  input logic RST,
  led_stream_capture_if.slave bus
);

  localparam logic [TIMER_W-1:0] T_LAST =
    TIMER_W'(FRAME_CYCLES - 1);

  logic [TIMER_W-1:0] timer;

  row_t [ROWS-1:0] cap_r;
  row_t [ROWS-1:0] cap_g;
  row_t [ROWS-1:0] disp_r;
  row_t [ROWS-1:0] disp_g;
  row_t [ROWS-1:0] cap_r_base;
  row_t [ROWS-1:0] cap_g_base;
  row_t [ROWS-1:0] cap_r_next;
  row_t [ROWS-1:0] cap_g_next;
  row_t [ROWS-1:0] pix;

  logic [7:0] c_r;
  logic [7:0] c_g;
  logic [7:0] c_r_next;
  logic [7:0] c_g_next;
  logic [7:0] cnt_r;
  logic [7:0] cnt_g;

  row_t rd_r;
  row_t rd_g;
  logic frame_done;

  logic       acc;
  logic       pr;
  logic       pg;
  logic [3:0] py;
  logic [2:0] px;
  logic       boundary;
  logic       set_r;
  logic       set_g;
  logic       new_r;
  logic       new_g;

  led_dwell_filter #(
    .MIN_DWELL(MIN_DWELL)
  ) u_dwell (
    .clk   (CLK),
    .rst   (RST),
    .ledin (bus.LEDIN),
    .accept(acc),
    .r     (pr),
    .g     (pg),
    .y     (py),
    .x     (px)
  );

  assign boundary = (timer == T_LAST) || bus.FRAME_SYNC;

  // Next capture state: a boundary clears first, then the accepted
  // pixel lands in the fresh buffer so it belongs to the new frame.
  always_comb begin
    cap_r_base = boundary ? '0 : cap_r;
    cap_g_base = boundary ? '0 : cap_g;
    pix = '0;
    pix[py][px] = 1'b1;
    set_r = acc && pr;
    set_g = acc && pg;
    new_r = set_r && !cap_r_base[py][px];
    new_g = set_g && !cap_g_base[py][px];
    cap_r_next = set_r ? (cap_r_base | pix) : cap_r_base;
    cap_g_next = set_g ? (cap_g_base | pix) : cap_g_base;
    c_r_next = (boundary ? 8'd0 : c_r) + {7'd0, new_r};
    c_g_next = (boundary ? 8'd0 : c_g) + {7'd0, new_g};
  end

  // Frame timer, capture/display buffers and lit-pixel counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer      <= '0;
      cap_r      <= '0;
      cap_g      <= '0;
      disp_r     <= '0;
      disp_g     <= '0;
      c_r        <= '0;
      c_g        <= '0;
      cnt_r      <= '0;
      cnt_g      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      cap_r      <= cap_r_next;
      cap_g      <= cap_g_next;
      c_r        <= c_r_next;
      c_g        <= c_g_next;
      if (boundary) begin
        timer  <= '0;
        disp_r <= cap_r;
        disp_g <= cap_g;
        cnt_r  <= c_r;
        cnt_g  <= c_g;
      end else begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

  // Registered row readback, one cycle behind RD_Y.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_r <= '0;
      rd_g <= '0;
    end else begin
      rd_r <= disp_r[bus.RD_Y];
      rd_g <= disp_g[bus.RD_Y];
    end
  end

  assign bus.RD_R       = rd_r;
  assign bus.RD_G       = rd_g;
  assign bus.FRAME_DONE = frame_done;
  assign bus.CNT_R      = cnt_r;
  assign bus.CNT_G      = cnt_g;

`ifdef LED_CAPTURE_DIFF_EN
  logic [ROWS-1:0] row_diff;
  logic [ROWS-1:0] diff_next;
  logic            changed;

  // Per-row comparison of the outgoing display against the new frame.
  always_comb begin
    diff_next = '0;
    for (int i = 0; i < ROWS; i++) begin
      diff_next[i] = (disp_r[i] != cap_r[i]) ||
                     (disp_g[i] != cap_g[i]);
    end
  end

  // Diff flags captured at each swap and held until the next one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_diff <= '0;
      changed  <= 1'b0;
    end else if (boundary) begin
      row_diff <= diff_next;
      changed  <= |diff_next;
    end
  end

  assign bus.ROW_DIFF = row_diff;
  assign bus.CHANGED  = changed;
`endif

endmodule

// File: tb/tb_led_stream_capture.sv
// tb_led_stream_capture: directed + randomized stimulus against a
// frame-level reference model (LED_CAPTURE_DIFF_EN adds diff checks).
module tb_led_stream_capture;
  import led_stream_pkg::*;

  localparam int FC = 64;
  localparam int MD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_stream_capture_if bus();

  led_stream_capture #(
    .FRAME_CYCLES(FC),
    .MIN_DWELL   (MD),
    .TIMER_W     (18)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [9:0] m_prev;
  int         m_run;
  int         m_timer;
  logic [7:0] m_cap_r  [16];
  logic [7:0] m_cap_g  [16];
  logic [7:0] m_disp_r [16];
  logic [7:0] m_disp_g [16];
  logic       m_done;
  logic [7:0] m_rd_r;
  logic [7:0] m_rd_g;
  logic [7:0] m_cnt_r;
  logic [7:0] m_cnt_g;
  logic [15:0] m_diff;
  logic       m_changed;

  logic [3:0] rdy;
  int         n;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '0;
    m_run = 0;
    m_timer = 0;
    for (int i = 0; i < 16; i++) begin
      m_cap_r[i] = '0;
      m_cap_g[i] = '0;
      m_disp_r[i] = '0;
      m_disp_g[i] = '0;
    end
    m_done = 0;
    m_rd_r = '0;
    m_rd_g = '0;
    m_cnt_r = '0;
    m_cnt_g = '0;
    m_diff = '0;
    m_changed = 0;
  endtask

  // Predicts the visible state after the next clock edge.
  task automatic model_step(input logic [9:0] led,
                            input logic sync,
                            input logic [3:0] ry);
    logic [9:0] w;
    logic acc;
    logic bnd;
    int pr_cnt;
    int pg_cnt;
    w = led & 10'h37F;
    if (w[9:8] == 2'b00) m_run = 0;
    else if (w == m_prev) m_run++;
    else m_run = 1;
    acc = (w[9:8] != 2'b00) && (m_run == MD);
    m_prev = w;
    m_rd_r = m_disp_r[ry];
    m_rd_g = m_disp_g[ry];
    bnd = (m_timer == FC - 1) || sync;
    m_done = bnd;
    if (bnd) begin
      pr_cnt = 0;
      pg_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        m_diff[i] = (m_disp_r[i] != m_cap_r[i]) ||
                    (m_disp_g[i] != m_cap_g[i]);
        pr_cnt += $countones(m_cap_r[i]);
        pg_cnt += $countones(m_cap_g[i]);
        m_disp_r[i] = m_cap_r[i];
        m_disp_g[i] = m_cap_g[i];
        m_cap_r[i] = '0;
        m_cap_g[i] = '0;
      end
      m_changed = |m_diff;
      m_cnt_r = 8'(pr_cnt);
      m_cnt_g = 8'(pg_cnt);
      m_timer = 0;
    end else begin
      m_timer++;
    end
    if (acc) begin
      if (w[9]) m_cap_r[w[6:3]][w[2:0]] = 1'b1;
      if (w[8]) m_cap_g[w[6:3]][w[2:0]] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("frame_done", 32'(bus.FRAME_DONE), 32'(m_done));
    chk("rd_r", 32'(bus.RD_R), 32'(m_rd_r));
    chk("rd_g", 32'(bus.RD_G), 32'(m_rd_g));
    chk("cnt_r", 32'(bus.CNT_R), 32'(m_cnt_r));
    chk("cnt_g", 32'(bus.CNT_G), 32'(m_cnt_g));
`ifdef LED_CAPTURE_DIFF_EN
    chk("row_diff", 32'(bus.ROW_DIFF), 32'(m_diff));
    chk("changed", 32'(bus.CHANGED), 32'(m_changed));
`endif
  endtask

  // Called at a falling edge; drives, predicts, then checks.
  task automatic cycle(input logic [9:0] led,
                       input logic sync,
                       input logic [3:0] ry);
    bus.LEDIN = led;
    bus.FRAME_SYNC = sync;
    bus.RD_Y = ry;
    model_step(led, sync, ry);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic hold(input logic [9:0] w, input int len);
    for (int i = 0; i < len; i++) cycle(w, 1'b0, rdy);
  endtask

  task automatic run_until_done(input int limit, output int cnt);
    logic found;
    found = 1'b0;
    cnt = 0;
    while (!found && cnt < limit) begin
      cycle(10'd0, 1'b0, rdy);
      cnt++;
      found = bus.FRAME_DONE;
    end
    chk("done_timeout", 32'(found), 32'd1);
  endtask

  task automatic wait_timer(input int t);
    int k;
    k = 0;
    while (m_timer != t && k < 4 * FC) begin
      cycle(10'd0, 1'b0, rdy);
      k++;
    end
  endtask

  function automatic logic [9:0] pw(input logic r, input logic g,
                                    input int y, input int x);
    return {r, g, 1'b0, 4'(y), 3'(x)};
  endfunction

  initial begin
    logic [9:0] w;
    int len;
    int cyc;
    bus.LEDIN = '0;
    bus.FRAME_SYNC = 1'b0;
    bus.RD_Y = '0;
    rdy = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Accept and count
    hold(10'b10_0_1100_011, 4);
    run_until_done(4 * FC, n);
    rdy = 4'd12;
    cycle(10'd0, 1'b0, rdy);
    chk("s1_rd_r", 32'(bus.RD_R), 32'h08);
    chk("s1_cnt_r", 32'(bus.CNT_R), 32'd1);
    chk("s1_cnt_g", 32'(bus.CNT_G), 32'd0);

    // Glitch reject
    hold(10'b10_0_1100_011, 3);
    run_until_done(4 * FC, n);
    chk("glitch_cnt_r", 32'(bus.CNT_R), 32'd0);

    // Duplicates and two colours
    hold(pw(1, 0, 3, 5), 4);
    cycle(10'd0, 1'b0, rdy);
    hold(pw(1, 0, 3, 5), 4);
    hold(pw(1, 1, 0, 0), 4);
    run_until_done(4 * FC, n);
    chk("dup_cnt_r", 32'(bus.CNT_R), 32'd2);
    chk("dup_cnt_g", 32'(bus.CNT_G), 32'd1);

    // Boundary collision
    wait_timer(60);
    hold(pw(0, 1, 7, 6), 4);
    chk("col_done", 32'(bus.FRAME_DONE), 32'd1);
    chk("col_out_g", 32'(bus.CNT_G), 32'd0);
    run_until_done(4 * FC, n);
    chk("col_next_g", 32'(bus.CNT_G), 32'd1);

    // FRAME_SYNC mid-frame
    hold(pw(1, 0, 9, 1), 4);
    wait_timer(20);
    cycle(10'd0, 1'b1, rdy);
    chk("sync_done", 32'(bus.FRAME_DONE), 32'd1);
    chk("sync_cnt_r", 32'(bus.CNT_R), 32'd1);
    run_until_done(4 * FC, n);
    chk("sync_gap", 32'(n), 32'(FC));

    // FRAME_SYNC on the last timer cycle
    wait_timer(FC - 1);
    cycle(10'd0, 1'b1, rdy);
    chk("sync_last_done", 32'(bus.FRAME_DONE), 32'd1);
    cycle(10'd0, 1'b0, rdy);
    chk("sync_last_single", 32'(bus.FRAME_DONE), 32'd0);
    run_until_done(4 * FC, n);
    chk("sync_last_gap", 32'(n), 32'(FC - 1));

    // Randomized traffic
    cyc = 0;
    while (cyc < 3000) begin
      if ($urandom_range(0, 3) == 0) w = '0;
      else w = pw(1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)));
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        cycle(w | {2'b00, 1'($urandom), 7'd0},
              ($urandom_range(0, 99) == 0),
              4'($urandom_range(0, 15)));
        cyc++;
      end
    end

`ifdef LED_CAPTURE_DIFF_EN
    // Frame diff
    run_until_done(4 * FC, n);
    hold(pw(1, 0, 2, 0), 4);
    run_until_done(4 * FC, n);
    hold(pw(1, 0, 2, 0), 4);
    run_until_done(4 * FC, n);
    chk("diff_same", 32'(bus.CHANGED), 32'd0);
    hold(pw(1, 0, 5, 0), 4);
    run_until_done(4 * FC, n);
    chk("diff_move", 32'(bus.ROW_DIFF), 32'h0024);
    chk("diff_chg", 32'(bus.CHANGED), 32'd1);
`endif

    // Reset mid-frame
    rdy = 4'd2;
    hold(pw(1, 1, 2, 4), 4);
    run_until_done(4 * FC, n);
    cycle(10'd0, 1'b0, rdy);
    hold(pw(1, 0, 6, 6), 4);
    wait_timer(30);
    rst = 1'b1;
    #1;
    chk("rst_rd_r", 32'(bus.RD_R), 32'd0);
    chk("rst_rd_g", 32'(bus.RD_G), 32'd0);
    chk("rst_cnt_r", 32'(bus.CNT_R), 32'd0);
    chk("rst_cnt_g", 32'(bus.CNT_G), 32'd0);
    chk("rst_done", 32'(bus.FRAME_DONE), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_until_done(4 * FC, n);
    chk("rst_first_gap", 32'(n), 32'(FC));
    chk("rst_cnt_after", 32'(bus.CNT_R), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
